// File: rtl/tap_decoder.sv
// Classifies single-cycle pulse strobes as single or double taps, with a
// post-double-tap lockout and wrapping 8-bit event counters.
module tap_decoder #(
  parameter int WINDOW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse,
  output logic       single_tap,
  output logic       double_tap,
  output logic       busy,
  output logic [7:0] n_single,
  output logic [7:0] n_double
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] LOCK = 2'b10;
  localparam logic [7:0] WIN  = 8'(WINDOW);

  logic [1:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       single_q, single_d;
  logic       double_q, double_d;
  logic [7:0] n_single_q, n_single_d;
  logic [7:0] n_double_q, n_double_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    single_d   = 1'b0;
    double_d   = 1'b0;
    n_single_d = n_single_q;
    n_double_d = n_double_q;
    case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d = WAIT;
          timer_d = 8'd1;
        end
      end
      WAIT: begin
        // A pulse on the closing edge of the window still wins as a double tap.
        if (pulse) begin
          double_d   = 1'b1;
          n_double_d = n_double_q + 8'd1;
          state_d    = LOCK;
          timer_d    = 8'd1;
        end else if (timer_q == WIN) begin
          single_d   = 1'b1;
          n_single_d = n_single_q + 8'd1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      LOCK: begin
        if (timer_q == WIN) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= 8'd0;
      single_q   <= 1'b0;
      double_q   <= 1'b0;
      n_single_q <= 8'd0;
      n_double_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      single_q   <= single_d;
      double_q   <= double_d;
      n_single_q <= n_single_d;
      n_double_q <= n_double_d;
    end
  end

  assign single_tap = single_q;
  assign double_tap = double_q;
  assign busy       = (state_q != IDLE);
  assign n_single   = n_single_q;
  assign n_double   = n_double_q;

endmodule

// File: tb/tb_tap_decoder.sv
// Bench for tap_decoder: table-driven pulse patterns plus hand sequences,
// with a scoreboard of expected strobe edges checked on every clock edge.
module tb_tap_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pulse = 1'b0;
  logic       single_tap, double_tap, busy;
  logic [7:0] n_single, n_double;

  tap_decoder #(.WINDOW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse      (pulse),
    .single_tap (single_tap),
    .double_tap (double_tap),
    .busy       (busy),
    .n_single   (n_single),
    .n_double   (n_double)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit dbl;
  } ev_t;

  // p2/p3: extra pulse offsets relative to the first pulse (-1 = none);
  // e1/e2: expected strobe edge offsets (-1 = none), d1/d2: 1 = double tap.
  typedef struct {
    int p2;
    int p3;
    int e1;
    bit d1;
    int e2;
    bit d2;
  } vec_t;

  ev_t        sb[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  logic [7:0] exp_ns = 8'd0;
  logic [7:0] exp_nd = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d edge=%0d", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every edge either matches the scoreboard head or shows no strobe.
  always @(posedge clk) begin
    ev_t ev;
    #1;
    edge_cnt++;
    if (!reset) begin
      exp_ns = 8'd0;
      exp_nd = 8'd0;
    end
    if (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
      ev = sb.pop_front();
      chk("missed_strobe", 0, ev.edge_no);
    end
    if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
      ev = sb.pop_front();
      if (ev.dbl) exp_nd = exp_nd + 8'd1;
      else        exp_ns = exp_ns + 8'd1;
      chk("single_tap", int'(single_tap), int'(!ev.dbl));
      chk("double_tap", int'(double_tap), int'(ev.dbl));
      chk("n_single", int'(n_single), int'(exp_ns));
      chk("n_double", int'(n_double), int'(exp_nd));
      $display("txn edge=%0d kind=%s n_single=%0d n_double=%0d",
               edge_cnt, ev.dbl ? "double" : "single", n_single, n_double);
    end else begin
      chk("idle_single_tap", int'(single_tap), 0);
      chk("idle_double_tap", int'(double_tap), 0);
    end
  end

  task automatic push_ev(input int edge_no, input bit dbl);
    ev_t ev;
    ev.edge_no = edge_no;
    ev.dbl     = dbl;
    sb.push_back(ev);
  endtask

  task automatic run_vec(input vec_t v, input int len);
    int base;
    for (int rel = 0; rel < len; rel++) begin
      @(negedge clk);
      if (rel == 0) begin
        base = edge_cnt + 1;
        if (v.e1 >= 0) push_ev(base + v.e1, v.d1);
        if (v.e2 >= 0) push_ev(base + v.e2, v.d2);
      end
      pulse = (rel == 0) || (rel == v.p2) || (rel == v.p3);
    end
    @(negedge clk);
    pulse = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t single_v;

    vecs[0] = '{-1, -1, 8, 1'b0, -1, 1'b0};
    vecs[1] = '{ 1, -1, 1, 1'b1, -1, 1'b0};
    vecs[2] = '{ 3,  6, 3, 1'b1, -1, 1'b0};
    vecs[3] = '{ 3, 11, 3, 1'b1, -1, 1'b0};
    vecs[4] = '{ 3, 12, 3, 1'b1, 20, 1'b0};
    vecs[5] = '{ 8, -1, 8, 1'b1, -1, 1'b0};
    vecs[6] = '{ 9, -1, 8, 1'b0, 17, 1'b0};
    vecs[7] = '{ 9, 10, 8, 1'b0, 10, 1'b1};
    single_v = '{-1, -1, 8, 1'b0, -1, 1'b0};

    // Reset, then 20 quiet cycles.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_n_single", int'(n_single), 0);
    chk("reset_n_double", int'(n_double), 0);

    // Busy spans the edges after the first pulse until the single tap decides.
    @(negedge clk);
    pulse = 1'b1;
    push_ev(edge_cnt + 1 + 8, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk);
      #2;
      pulse = 1'b0;
      chk("busy_window", int'(busy), (i < 8) ? 1 : 0);
    end
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], 34);
      chk("vec_end_busy", int'(busy), 0);
    end

    // Asynchronous reset in the middle of a WAIT discards the pending tap.
    @(negedge clk);
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_n_single", int'(n_single), 0);
    chk("async_n_double", int'(n_double), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_reset_n_single", int'(n_single), 0);
    chk("post_reset_busy", int'(busy), 0);

    // Counter wrap: 256 single taps return n_single to 0, one more makes 1.
    for (int i = 0; i < 256; i++) run_vec(single_v, 10);
    repeat (2) @(negedge clk);
    chk("wrap_n_single", int'(n_single), 0);
    chk("wrap_n_double", int'(n_double), 0);
    run_vec(single_v, 10);
    repeat (2) @(negedge clk);
    chk("wrap_plus1_n_single", int'(n_single), 1);
    chk("wrap_plus1_n_double", int'(n_double), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
